// File: rtl/gf2m8_field_unit.sv
`default_nettype none
// ============================================================================
//  Module      : gf2m8_field_unit
//  Description : GF(2^8) arithmetic primitives for the RS decoder KES stage:
//                a combinational field multiplier, a combinational field
//                inverter (b^254) and a glitch-free integrated clock gate
//                for the KES R/Q/L/U register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf2m8_field_unit #(
    parameter logic [7:0] POLY = 8'h1D   // low byte of field polynomial, x^8 implied
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output logic       gclk,
    input  logic [7:0] x,
    input  logic [7:0] y,
    output logic [7:0] z,
    input  logic [7:0] b,
    output logic [7:0] b_inv
);

    // Carry-less 8x8 product followed by reduction of bits 14..8, highest
    // first, so any bit re-set by a reduction step is cleared by a later one.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] m);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                p = p ^ (15'(a) << i);
            end
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) begin
                p[k] = 1'b0;
                p    = p ^ (15'(POLY) << (k - 8));
            end
        end
        return p[7:0];
    endfunction

    // Square-and-multiply chain for b^254 = b^-1; b = 0 yields 0 naturally.
    logic [7:0] w_p2, w_p3, w_p6, w_p7, w_p14, w_p15, w_p30, w_p31;
    logic [7:0] w_p62, w_p63, w_p126, w_p127, w_p254;

    // Field multiplier output
    assign z = gf_mul(x, y);

    // Inverter exponentiation chain
    assign w_p2   = gf_mul(b, b);
    assign w_p3   = gf_mul(w_p2, b);
    assign w_p6   = gf_mul(w_p3, w_p3);
    assign w_p7   = gf_mul(w_p6, b);
    assign w_p14  = gf_mul(w_p7, w_p7);
    assign w_p15  = gf_mul(w_p14, b);
    assign w_p30  = gf_mul(w_p15, w_p15);
    assign w_p31  = gf_mul(w_p30, b);
    assign w_p62  = gf_mul(w_p31, w_p31);
    assign w_p63  = gf_mul(w_p62, b);
    assign w_p126 = gf_mul(w_p63, w_p63);
    assign w_p127 = gf_mul(w_p126, b);
    assign w_p254 = gf_mul(w_p127, w_p127);
    assign b_inv  = w_p254;

    // Enable latch: transparent while clk is low, so ena changes during the
    // high phase cannot reach gclk until the next low phase. Reset clears it
    // immediately, which may truncate a pulse in progress.
    logic r_en_q;

    always_latch begin
        if (rst) begin
            r_en_q <= 1'b0;
        end else if (!clk) begin
            r_en_q <= ena;
        end
    end

    // Gated clock: AND of clock with the held enable
    assign gclk = clk & r_en_q;

endmodule
`default_nettype wire

// File: tb/tb_gf2m8_field_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf2m8_field_unit
//  Description : Self-checking bench for gf2m8_field_unit: vector table,
//                exhaustive/random field arithmetic against a reference
//                model, and clock-gate sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2m8_field_unit;

    localparam logic [7:0] c_POLY = 8'h1D;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       gclk;
    logic [7:0] x, y, z, b, b_inv;

    int checks   = 0;
    int failures = 0;

    gf2m8_field_unit #(.POLY(c_POLY)) dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .gclk (gclk),
        .x    (x),
        .y    (y),
        .z    (z),
        .b    (b),
        .b_inv(b_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // gclk pulse counter and pulse-width monitor (full pulse = half period)
    int  gcnt  = 0;
    int  bad_w = 0;
    time t_rise = 0;
    always @(posedge gclk) begin
        gcnt   <= gcnt + 1;
        t_rise <= $time;
    end
    always @(negedge gclk) begin
        if (($time - t_rise) != 5) bad_w <= bad_w + 1;
    end

    // Reference multiply: shift-and-add with xtime doubling
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] r, aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r = r ^ aa;
            aa = aa[7] ? ((aa << 1) ^ c_POLY) : (aa << 1);
        end
        return r;
    endfunction

    logic [7:0] inv_tbl [256];
    logic [7:0] zz [256][256];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] vx, vy, vz, vb, vbinv;
    } vec_t;
    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, w0, bad, first;
        logic [7:0] act;

        vecs[0] = '{8'h02, 8'h80, 8'h1D, 8'h01, 8'h01};
        vecs[1] = '{8'h03, 8'h03, 8'h05, 8'h02, 8'h8E};
        vecs[2] = '{8'h00, 8'hA7, 8'h00, 8'h8E, 8'h02};
        vecs[3] = '{8'h01, 8'hC4, 8'hC4, 8'h00, 8'h00};
        vecs[4] = '{8'hFF, 8'hFF, 8'hE2, 8'h01, 8'h01};

        // Inverse table by search on the reference multiplier
        inv_tbl[0] = 8'h00;
        for (int i = 1; i < 256; i++) begin
            inv_tbl[i] = 8'h00;
            for (int c = 1; c < 256; c++)
                if (ref_mul(8'(i), 8'(c)) == 8'h01) inv_tbl[i] = 8'(c);
        end

        rst = 1'b1; ena = 1'b1; x = '0; y = '0; b = '0;

        // Reset state: no gated pulses while rst is held, even with ena=1
        repeat (3) @(negedge clk);
        chk("reset_gclk", {7'b0, gclk}, 8'h00);
        chki("reset_no_pulses", gcnt, 0);
        ena = 1'b0;
        #1 rst = 1'b0;

        // Vector table
        for (int i = 0; i < 5; i++) begin
            x = vecs[i].vx; y = vecs[i].vy; b = vecs[i].vb;
            #1;
            chk($sformatf("vec%0d_z", i), z, vecs[i].vz);
            chk($sformatf("vec%0d_binv", i), b_inv, vecs[i].vbinv);
        end

        // Exhaustive multiply, one comparison per x row
        for (int i = 0; i < 256; i++) begin
            bad = 0; first = 0; act = '0;
            for (int j = 0; j < 256; j++) begin
                x = 8'(i); y = 8'(j);
                #1;
                zz[i][j] = z;
                if (z !== ref_mul(8'(i), 8'(j)) && bad == 0) begin
                    bad = 1; first = j; act = z;
                end
            end
            if (bad != 0) chk($sformatf("mul_row x=%02h y=%02h", i, first), act, ref_mul(8'(i), 8'(first)));
            else chk($sformatf("mul_row x=%02h", i), zz[i][255], ref_mul(8'(i), 8'hFF));
        end

        // Commutativity, one comparison per row
        for (int i = 0; i < 256; i++) begin
            first = -1;
            for (int j = 0; j < 256; j++)
                if (zz[i][j] !== zz[j][i] && first < 0) first = j;
            if (first >= 0) chk($sformatf("commute x=%02h y=%02h", i, first), zz[i][first], zz[first][i]);
            else chk($sformatf("commute x=%02h", i), zz[i][i], ref_mul(8'(i), 8'(i)));
        end

        // Inverse sweep: table match and b*b_inv = 1
        for (int i = 1; i < 256; i++) begin
            b = 8'(i);
            #1;
            chk($sformatf("inv b=%02h", i), b_inv, inv_tbl[i]);
            x = b; y = b_inv;
            #1;
            chk($sformatf("inv_prod b=%02h", i), z, 8'h01);
        end
        b = 8'h00;
        #1 chk("inv_zero", b_inv, 8'h00);

        // Random operands
        for (int k = 0; k < 100; k++) begin
            x = 8'($urandom); y = 8'($urandom); b = 8'($urandom);
            #1;
            chk($sformatf("rand_mul %02h*%02h", x, y), z, ref_mul(x, y));
            chk($sformatf("rand_inv %02h", b), b_inv, inv_tbl[b]);
        end

        // ICG: ena high for 3 cycles then low for 2 -> 3 full pulses
        c0 = gcnt; w0 = bad_w;
        @(negedge clk); ena = 1'b1;
        repeat (3) @(negedge clk);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chki("icg_three_pulses", gcnt - c0, 3);

        // ICG: ena alternating each cycle -> one pulse per enabled cycle
        c0 = gcnt;
        for (int k = 0; k < 5; k++) begin
            ena = (k % 2 == 0);
            @(negedge clk);
        end
        ena = 1'b0;
        @(negedge clk);
        chki("icg_alternate", gcnt - c0, 3);

        // ICG glitch: ena toggled during the high phase must not disturb gclk
        c0 = gcnt;
        ena = 1'b1;
        @(posedge clk);
        #1 ena = 1'b0; #1 ena = 1'b1; #1 ena = 1'b0;
        #1 chk("glitch_hold_high", {7'b0, gclk}, 8'h01);
        @(negedge clk);
        @(posedge clk);
        #1 ena = 1'b1; #1 ena = 1'b0; #1 ena = 1'b1;
        #1 chk("glitch_hold_low", {7'b0, gclk}, 8'h00);
        ena = 1'b0;
        repeat (2) @(negedge clk);
        chki("glitch_pulse_count", gcnt - c0, 1);
        chki("pulse_widths", bad_w - w0, 0);

        // Reset mid-high-phase with ena=1: gclk drops at once, no pulses
        ena = 1'b1;
        @(posedge clk);
        #2 chk("pre_reset_high", {7'b0, gclk}, 8'h01);
        rst = 1'b1;
        #1 chk("reset_immediate", {7'b0, gclk}, 8'h00);
        c0 = gcnt;
        repeat (3) @(negedge clk);
        chki("reset_held_no_pulses", gcnt - c0, 0);
        // Release during high phase: stays low until the next low phase
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("release_high_phase", {7'b0, gclk}, 8'h00);
        @(posedge clk);
        #1 chk("resume_pulse", {7'b0, gclk}, 8'h01);
        @(negedge clk);
        ena = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
